// File: rtl/sx_pkg.sv
// Shared definitions for the slot arbiter: FSM state encoding, default fill
// byte and channel encodings.
package sx_pkg;

  // One-hot state encoding
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARB   = 5'b00010,
    READ  = 5'b00100,
    PAD   = 5'b01000,
    DRAIN = 5'b10000
  } sx_state_e;

  localparam logic [7:0] SX_PAD_BYTE = 8'hAA;

  localparam logic CH1 = 1'b0;  // control channel, tx_data1
  localparam logic CH2 = 1'b1;  // service channel, tx_data2

endpackage

// File: rtl/sx_rr_pick.sv
// Combinational round-robin priority encoder.
// Ports:
//   eligible : request mask
//   rr_ptr   : index searched first; search proceeds upward with wrap
//   hit      : at least one eligible request
//   idx      : selected index (0 when no hit)
module sx_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // First eligible index at or above rr_ptr, wrapping past N-1
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (32'(rr_ptr) + k) % N;
      if (!hit && eligible[IW'(j)]) begin
        hit = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sx_slot_arbiter.sv
// Shares framer transmit slots between N_SRC byte-stream source FIFOs.
// Each announced slot is granted to one source by round-robin; up to slot_len
// bytes are drained from it and the remainder is filled with PAD_BYTE.
// Ports:
//   clk163m84, rst       : clock, asynchronous active-high reset
//   slot_req/chan/len    : slot announce, channel (0 = ch1, 1 = ch2), length
//   src_en/empty/cnt/data: per-source enable, FIFO status and read data
//   src_rd_en            : one-hot FIFO read strobe
//   tx_data1_*, tx_data2_*: framer byte streams for ch1 / ch2
//   busy, grant_id       : slot in progress, source granted for the slot
//   slot_ovr             : pulse when a slot_req is dropped
// Optional: define SX_SLOT_ARB_STAT_EN to add stat_bytes / stat_pad counters.
module sx_slot_arbiter
  import sx_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned CNT_W    = 13,
  parameter int unsigned LEN_W    = 16,
  parameter logic [7:0]  PAD_BYTE = SX_PAD_BYTE
) (
  input  logic                     clk163m84,
  input  logic                     rst,
  input  logic                     slot_req,
  input  logic                     slot_chan,
  input  logic [LEN_W-1:0]         slot_len,
  input  logic [N_SRC-1:0]         src_en,
  input  logic [N_SRC-1:0]         src_empty,
  input  logic [N_SRC*CNT_W-1:0]   src_cnt,
  input  logic [N_SRC*8-1:0]       src_data,
  output logic [N_SRC-1:0]         src_rd_en,
  output logic [7:0]               tx_data1_in,
  output logic                     tx_data1_valid_in,
  output logic [7:0]               tx_data2_in,
  output logic                     tx_data2_valid_in,
  output logic                     busy,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     slot_ovr
`ifdef SX_SLOT_ARB_STAT_EN
  ,
  output logic [N_SRC*32-1:0]      stat_bytes,
  output logic [31:0]              stat_pad
`endif
);

  localparam int unsigned IW = $clog2(N_SRC);
  localparam int unsigned RW = LEN_W + 1;
  localparam int unsigned MW = (CNT_W > RW) ? CNT_W : RW;

  sx_state_e       state;
  logic            chan_q;
  logic [LEN_W-1:0] len_q;
  logic [RW-1:0]   rd_n;
  logic [RW-1:0]   rd_cnt;
  logic [RW-1:0]   pad_n;
  logic [RW-1:0]   pad_cnt;
  logic            drain_cnt;
  logic [IW-1:0]   rr_ptr;
  logic            pad_iss;
  logic            rd_d1;
  logic            pad_d1;

  logic [N_SRC-1:0] eligible_c;
  logic             hit_c;
  logic [IW-1:0]    pick_c;
  logic [MW-1:0]    cnt_ext_c;
  logic [MW-1:0]    len_ext_c;
  logic [RW-1:0]    rd_n_c;
  logic [IW-1:0]    rr_next_c;
  logic             beat_c;
  logic [7:0]       byte_c;

  assign eligible_c = src_en & ~src_empty;

  sx_rr_pick #(.N(N_SRC)) u_pick (
    .eligible (eligible_c),
    .rr_ptr   (rr_ptr),
    .hit      (hit_c),
    .idx      (pick_c)
  );

  // Read count = min(count of picked source, slot length)
  assign cnt_ext_c = MW'(src_cnt[32'(pick_c)*CNT_W +: CNT_W]);
  assign len_ext_c = MW'(len_q);
  assign rd_n_c    = RW'((cnt_ext_c < len_ext_c) ? cnt_ext_c : len_ext_c);
  assign rr_next_c = (pick_c == IW'(N_SRC - 1)) ? '0 : pick_c + IW'(1);

  // Slot sequencing FSM; src_rd_en and pad_iss are the beat issue strobes
  always_ff @(posedge clk163m84 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      chan_q    <= CH1;
      len_q     <= '0;
      rd_n      <= '0;
      rd_cnt    <= '0;
      pad_n     <= '0;
      pad_cnt   <= '0;
      drain_cnt <= 1'b0;
      rr_ptr    <= '0;
      pad_iss   <= 1'b0;
      src_rd_en <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      slot_ovr  <= 1'b0;
    end else begin
      slot_ovr <= 1'b0;
      if (slot_req && (state != IDLE)) slot_ovr <= 1'b1;
      case (state)
        IDLE: begin
          if (slot_req) begin
            if (slot_len == '0) begin
              slot_ovr <= 1'b1;
            end else begin
              chan_q <= slot_chan;
              len_q  <= slot_len;
              busy   <= 1'b1;
              state  <= ARB;
            end
          end
        end
        ARB: begin
          if (hit_c) begin
            grant_id <= pick_c;
            rr_ptr   <= rr_next_c;
            rd_n     <= rd_n_c;
            pad_n    <= RW'(len_q) - rd_n_c;
            if (rd_n_c != '0) begin
              src_rd_en <= N_SRC'(1) << pick_c;
              rd_cnt    <= RW'(1);
              state     <= READ;
            end else begin
              pad_iss <= 1'b1;
              pad_cnt <= RW'(1);
              state   <= PAD;
            end
          end else begin
            rd_n    <= '0;
            pad_n   <= RW'(len_q);
            pad_iss <= 1'b1;
            pad_cnt <= RW'(1);
            state   <= PAD;
          end
        end
        READ: begin
          if (rd_cnt < rd_n) begin
            src_rd_en <= N_SRC'(1) << grant_id;
            rd_cnt    <= rd_cnt + RW'(1);
          end else begin
            src_rd_en <= '0;
            drain_cnt <= 1'b0;
            if (pad_n != '0) begin
              // Pad issue starts right after the last read for a gapless stream
              pad_iss <= 1'b1;
              pad_cnt <= RW'(1);
              state   <= PAD;
            end else begin
              state <= DRAIN;
            end
          end
        end
        PAD: begin
          if (pad_cnt < pad_n) begin
            pad_cnt <= pad_cnt + RW'(1);
          end else begin
            pad_iss   <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // Two cycles covers FIFO latency plus the output register
          if (drain_cnt) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign beat_c = rd_d1 | pad_d1;
  assign byte_c = rd_d1 ? src_data[32'(grant_id)*8 +: 8] : PAD_BYTE;

  // Output stage: FIFO data arrives one cycle after rd_en, then is registered
  always_ff @(posedge clk163m84 or posedge rst) begin
    if (rst) begin
      rd_d1             <= 1'b0;
      pad_d1            <= 1'b0;
      tx_data1_in       <= 8'h00;
      tx_data1_valid_in <= 1'b0;
      tx_data2_in       <= 8'h00;
      tx_data2_valid_in <= 1'b0;
`ifdef SX_SLOT_ARB_STAT_EN
      stat_bytes        <= '0;
      stat_pad          <= '0;
`endif
    end else begin
      rd_d1             <= |src_rd_en;
      pad_d1            <= pad_iss;
      tx_data1_valid_in <= beat_c && (chan_q == CH1);
      tx_data1_in       <= (beat_c && (chan_q == CH1)) ? byte_c : 8'h00;
      tx_data2_valid_in <= beat_c && (chan_q == CH2);
      tx_data2_in       <= (beat_c && (chan_q == CH2)) ? byte_c : 8'h00;
`ifdef SX_SLOT_ARB_STAT_EN
      if (rd_d1)
        stat_bytes[32'(grant_id)*32 +: 32] <= stat_bytes[32'(grant_id)*32 +: 32] + 32'd1;
      if (pad_d1)
        stat_pad <= stat_pad + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_sx_slot_arbiter.sv
// Self-checking bench for sx_slot_arbiter: behavioural source FIFOs, a
// round-robin reference model and a beat scoreboard.
module tb_sx_slot_arbiter;

  typedef struct packed {
    logic       ch;
    logic [7:0] d;
  } beat_t;
  typedef logic [7:0] bq_t [$];

  logic        clk163m84 = 1'b0;
  logic        rst;
  logic        slot_req;
  logic        slot_chan;
  logic [15:0] slot_len;
  logic [3:0]  src_en;
  logic [3:0]  src_empty;
  logic [51:0] src_cnt;
  logic [31:0] src_data;
  logic [3:0]  src_rd_en;
  logic [7:0]  tx_data1_in;
  logic        tx_data1_valid_in;
  logic [7:0]  tx_data2_in;
  logic        tx_data2_valid_in;
  logic        busy;
  logic [1:0]  grant_id;
  logic        slot_ovr;
`ifdef SX_SLOT_ARB_STAT_EN
  logic [127:0] stat_bytes;
  logic [31:0]  stat_pad;
`endif

  always #3 clk163m84 = ~clk163m84;

  sx_slot_arbiter dut (
    .clk163m84         (clk163m84),
    .rst               (rst),
    .slot_req          (slot_req),
    .slot_chan         (slot_chan),
    .slot_len          (slot_len),
    .src_en            (src_en),
    .src_empty         (src_empty),
    .src_cnt           (src_cnt),
    .src_data          (src_data),
    .src_rd_en         (src_rd_en),
    .tx_data1_in       (tx_data1_in),
    .tx_data1_valid_in (tx_data1_valid_in),
    .tx_data2_in       (tx_data2_in),
    .tx_data2_valid_in (tx_data2_valid_in),
    .busy              (busy),
    .grant_id          (grant_id),
    .slot_ovr          (slot_ovr)
`ifdef SX_SLOT_ARB_STAT_EN
    ,
    .stat_bytes        (stat_bytes),
    .stat_pad          (stat_pad)
`endif
  );

  bq_t   fq [4];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    m_rr     = 0;
  int    m_grant  = 0;
  int    cyc_n    = 0;
  int    first_beat = -1;
  int    last_beat  = -1;
  int    beats_n  = 0;
  int    ovr_cnt  = 0;
  logic  rd_seen  = 1'b0;

  task automatic update_counts();
    for (int i = 0; i < 4; i++) begin
      src_cnt[i*13 +: 13] = 13'(fq[i].size());
      src_empty[i]        = (fq[i].size() == 0);
    end
  endtask

  task automatic load_src(input int i, input int n, input int base);
    for (int k = 0; k < n; k++) fq[i].push_back(8'(base + k));
    update_counts();
  endtask

  // One clock: sample/score at negedge, then model FIFO reads taken at the posedge
  task automatic sb_cycle();
    logic [3:0] rd_snap;
    beat_t      e;
    beat_t      got;
    logic       other_bad;
    @(negedge clk163m84);
    rd_snap = src_rd_en;
    if (rst == 1'b0) begin
      if (src_rd_en != 4'b0) rd_seen = 1'b1;
      if (slot_ovr) ovr_cnt++;
      if (tx_data1_valid_in || tx_data2_valid_in) begin
        beats_n++;
        if (first_beat < 0) first_beat = cyc_n;
        last_beat = cyc_n;
        got.ch    = tx_data2_valid_in;
        got.d     = tx_data2_valid_in ? tx_data2_in : tx_data1_in;
        other_bad = tx_data2_valid_in ? (tx_data1_valid_in || tx_data1_in != 8'h00)
                                      : (tx_data2_in != 8'h00);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: got ch=%0d data=%02h, required no beat", got.ch, got.d);
        end else begin
          e = exp_q.pop_front();
          if (got !== e || other_bad)
            $display("FAIL beat: got ch=%0d data=%02h other_bad=%0d, required ch=%0d data=%02h",
                     got.ch, got.d, other_bad, e.ch, e.d);
          else
            n_pass++;
        end
      end
    end
    @(posedge clk163m84);
    #1;
    cyc_n++;
    for (int i = 0; i < 4; i++) begin
      if (rd_snap[i]) begin
        if (fq[i].size() > 0) src_data[i*8 +: 8] = fq[i].pop_front();
        else                  src_data[i*8 +: 8] = 8'h00;
      end
    end
    update_counts();
  endtask

  // Reference round-robin decision; pushes the expected beats of one slot
  task automatic plan_slot(input logic ch, input int len);
    int    g;
    int    rdn;
    beat_t b;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_rr + k) % 4;
      if (g < 0 && src_en[j] && fq[j].size() > 0) g = j;
    end
    rdn = 0;
    if (g >= 0) begin
      rdn = (fq[g].size() < len) ? fq[g].size() : len;
      for (int k = 0; k < rdn; k++) begin
        b.ch = ch;
        b.d  = fq[g][k];
        exp_q.push_back(b);
      end
      m_grant = g;
      m_rr    = (g + 1) % 4;
    end
    for (int k = rdn; k < len; k++) begin
      b.ch = ch;
      b.d  = 8'hAA;
      exp_q.push_back(b);
    end
  endtask

  task automatic start_slot(input logic ch, input int len);
    rd_seen    = 1'b0;
    ovr_cnt    = 0;
    beats_n    = 0;
    first_beat = -1;
    last_beat  = -1;
    slot_req   = 1'b1;
    slot_chan  = ch;
    slot_len   = 16'(len);
    sb_cycle();
    slot_req   = 1'b0;
    cyc_n      = 0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      sb_cycle();
      k++;
    end while ((busy || exp_q.size() != 0) && k < 200);
    n_checks++;
    if (busy || exp_q.size() != 0)
      $display("FAIL slot_done: busy=%0d beats_left=%0d after %0d cycles, required 0/0", busy, exp_q.size(), k);
    else
      n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_cycle();
    sb_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) fq[i].delete();
    exp_q.delete();
    m_rr    = 0;
    m_grant = 0;
    update_counts();
    sb_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; slot_req = 1'b0; slot_chan = 1'b0; slot_len = 16'd0;
    src_en = 4'hF; src_data = 32'h0;
    update_counts();
    sb_cycle();
    sb_cycle();
    n_checks++; if (src_rd_en !== 4'b0) $display("FAIL rst_rd_en: got %b, required 0000", src_rd_en); else n_pass++;
    n_checks++; if (tx_data1_valid_in !== 1'b0 || tx_data1_in !== 8'h00)
      $display("FAIL rst_tx1: got v=%b d=%02h, required 0/00", tx_data1_valid_in, tx_data1_in); else n_pass++;
    n_checks++; if (tx_data2_valid_in !== 1'b0 || tx_data2_in !== 8'h00)
      $display("FAIL rst_tx2: got v=%b d=%02h, required 0/00", tx_data2_valid_in, tx_data2_in); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d, required 0", grant_id); else n_pass++;
    n_checks++; if (slot_ovr !== 1'b0) $display("FAIL rst_ovr: got %b, required 0", slot_ovr); else n_pass++;
    rst = 1'b0;
    sb_cycle();
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b, required 0", busy); else n_pass++;
  endtask

  task automatic test_pad_fill();
    do_reset();
    load_src(0, 5, 8'h10);
    plan_slot(1'b1, 8);
    start_slot(1'b1, 8);
    wait_done();
    n_checks++; if (first_beat !== 3) $display("FAIL pad_latency: got %0d, required 3", first_beat); else n_pass++;
    n_checks++; if (beats_n !== 8 || last_beat - first_beat !== 7)
      $display("FAIL pad_contig: got %0d beats over %0d cycles, required 8 over 8", beats_n, last_beat - first_beat + 1); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL pad_grant: got %0d, required 0", grant_id); else n_pass++;
  endtask

`ifdef SX_SLOT_ARB_STAT_EN
  task automatic test_stats();
    n_checks++; if (stat_bytes[31:0] !== 32'd5) $display("FAIL stat_bytes0: got %0d, required 5", stat_bytes[31:0]); else n_pass++;
    n_checks++; if (stat_pad !== 32'd3) $display("FAIL stat_pad: got %0d, required 3", stat_pad); else n_pass++;
  endtask
`endif

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) load_src(i, 20, i * 40);
    for (int s = 0; s < 4; s++) begin
      plan_slot(1'b0, 10);
      start_slot(1'b0, 10);
      wait_done();
      n_checks++; if (grant_id !== 2'(m_grant) || m_grant !== s)
        $display("FAIL rr_grant: got %0d, required %0d", grant_id, s); else n_pass++;
      n_checks++; if (beats_n !== 10) $display("FAIL rr_beats: got %0d, required 10", beats_n); else n_pass++;
    end
  endtask

  task automatic test_all_empty();
    do_reset();
    load_src(2, 5, 8'h60);
    plan_slot(1'b0, 5);
    start_slot(1'b0, 5);
    wait_done();
    plan_slot(1'b0, 4);
    start_slot(1'b0, 4);
    wait_done();
    n_checks++; if (rd_seen !== 1'b0) $display("FAIL empty_rd_en: got reads=%b, required 0", rd_seen); else n_pass++;
    n_checks++; if (grant_id !== 2'd2) $display("FAIL empty_grant: got %0d, required 2", grant_id); else n_pass++;
    // Pointer must still be 3 after the empty slot
    load_src(0, 3, 8'h70);
    load_src(3, 3, 8'h80);
    plan_slot(1'b1, 3);
    start_slot(1'b1, 3);
    wait_done();
    n_checks++; if (grant_id !== 2'd3) $display("FAIL empty_rr_hold: got %0d, required 3", grant_id); else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    load_src(1, 6, 8'h30);
    plan_slot(1'b0, 6);
    start_slot(1'b0, 6);
    sb_cycle(); sb_cycle(); sb_cycle();
    slot_req = 1'b1; slot_chan = 1'b1; slot_len = 16'd3;
    sb_cycle();
    slot_req = 1'b0;
    wait_done();
    n_checks++; if (ovr_cnt !== 1) $display("FAIL ovr_busy: got %0d pulses, required 1", ovr_cnt); else n_pass++;
    n_checks++; if (beats_n !== 6) $display("FAIL ovr_stream: got %0d beats, required 6", beats_n); else n_pass++;
    ovr_cnt = 0; beats_n = 0;
    slot_req = 1'b1; slot_chan = 1'b0; slot_len = 16'd0;
    sb_cycle();
    slot_req = 1'b0;
    sb_cycle(); sb_cycle(); sb_cycle(); sb_cycle();
    n_checks++; if (ovr_cnt !== 1) $display("FAIL ovr_len0: got %0d pulses, required 1", ovr_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0 || beats_n !== 0)
      $display("FAIL len0_idle: got busy=%b beats=%0d, required 0/0", busy, beats_n); else n_pass++;
  endtask

  task automatic test_mask_and_reset();
    do_reset();
    src_en = 4'b0100;
    load_src(1, 10, 8'h20);
    load_src(2, 10, 8'h50);
    plan_slot(1'b1, 8);
    start_slot(1'b1, 8);
    sb_cycle(); sb_cycle(); sb_cycle();
    n_checks++; if (grant_id !== 2'd2 || m_grant !== 2) $display("FAIL mask_grant: got %0d, required 2", grant_id); else n_pass++;
    n_checks++; if (src_rd_en !== 4'b0100) $display("FAIL mask_rd_en: got %b, required 0100", src_rd_en); else n_pass++;
    rst = 1'b1;
    sb_cycle();
    n_checks++; if (src_rd_en !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0 || slot_ovr !== 1'b0)
      $display("FAIL midrst_ctl: got rd=%b busy=%b grant=%0d ovr=%b, required 0", src_rd_en, busy, grant_id, slot_ovr); else n_pass++;
    n_checks++; if (tx_data1_valid_in !== 1'b0 || tx_data2_valid_in !== 1'b0 || tx_data1_in !== 8'h00 || tx_data2_in !== 8'h00)
      $display("FAIL midrst_tx: got v1=%b v2=%b d1=%02h d2=%02h, required 0", tx_data1_valid_in, tx_data2_valid_in, tx_data1_in, tx_data2_in); else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    m_rr = 0; m_grant = 0;
    src_en = 4'hF;
    load_src(3, 4, 8'h90);
    sb_cycle();
    plan_slot(1'b0, 4);
    start_slot(1'b0, 4);
    wait_done();
    n_checks++; if (grant_id !== 2'd1) $display("FAIL rst_rr_restart: got %0d, required 1", grant_id); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pad_fill();
`ifdef SX_SLOT_ARB_STAT_EN
    test_stats();
`endif
    test_round_robin();
    test_all_empty();
    test_overrun();
    test_mask_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sx_slot_arbiter.md
Name: sx_slot_arbiter

Overview:
- Shares framer transmit slots between N_SRC byte-stream source FIFOs (control, service, circuit, etc.).
- The framer announces a slot with a channel select (ch1 = control/tx_data1, ch2 = service/tx_data2) and a byte length.
- The block grants one source per slot by round-robin, drains up to the slot length from that source, and pads the rest with PAD_BYTE.
- Sits between the uplink source FIFOs and the framer tx_data1/tx_data2 inputs.

Parameters:
- N_SRC, 4, number of source FIFOs (2..8).
- CNT_W, 13, width of each source data_count.
- LEN_W, 16, slot length width (bytes).
- PAD_BYTE, 8'hAA, fill byte.

Ports:
- clk163m84  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- slot_req  in  1  one-cycle slot announce.
- slot_chan  in  1  0 = ch1 (tx_data1), 1 = ch2 (tx_data2); sampled with slot_req.
- slot_len  in  LEN_W  slot length in bytes; sampled with slot_req.
- src_en  in  N_SRC  per-source enable mask.
- src_empty  in  N_SRC  FIFO empty flags.
- src_cnt  in  N_SRC*CNT_W  packed FIFO data_count; source i at [i*CNT_W +: CNT_W].
- src_data  in  N_SRC*8  packed FIFO dout; standard FIFO, valid 1 cycle after rd_en.
- src_rd_en  out  N_SRC  one-hot FIFO read strobe.
- tx_data1_in  out  8  ch1 byte.
- tx_data1_valid_in  out  1  ch1 byte valid.
- tx_data2_in  out  8  ch2 byte.
- tx_data2_valid_in  out  1  ch2 byte valid.
- busy  out  1  slot in progress.
- grant_id  out  $clog2(N_SRC)  source granted for the current/last slot.
- slot_ovr  out  1  one-cycle pulse: slot_req dropped while busy or slot_len == 0.

Behaviour:
- Reset: all outputs 0; rr_ptr = 0; state IDLE.
- States:
  - IDLE: on slot_req with slot_len != 0, latch chan and len, go to ARB. slot_len == 0 pulses slot_ovr and stays in IDLE.
  - ARB (1 cycle): eligible = src_en & ~src_empty. Pick the first eligible index searching upward from rr_ptr, with wrap.
    - Hit: grant_id = g; rd_n = min(src_cnt[g], len), computed at LEN_W+1 width; rr_ptr = (g+1) mod N_SRC; go to READ.
    - No hit: rd_n = 0; grant_id unchanged; rr_ptr unchanged; go to PAD.
  - READ: assert src_rd_en[g] for rd_n consecutive cycles, then go to PAD if rd_n < len, else DRAIN.
  - PAD: emit (len - rd_n) PAD_BYTE beats, then DRAIN.
  - DRAIN: wait for the pipeline to empty (2 cycles), then return to IDLE.
- Latency and stream timing:
  - src_rd_en at cycle c produces the tx beat at c+2 (FIFO latency + output register).
  - Pad beats follow the last data beat with no gap.
  - Each slot is exactly len contiguous valid beats on the latched channel only; the other channel holds data 0 / valid 0.
- busy is high from the cycle after an accepted slot_req through the last DRAIN cycle.
- slot_req while busy: dropped, slot_ovr pulses; the current slot is unaffected.
- A source becoming empty mid-READ is not expected, since rd_n ≤ its latched count. If it happens anyway, reads continue and the FIFO underflow data is passed through; no recovery is attempted.
- src_en changes take effect at the next ARB only.
- Reset mid-slot: all state and outputs clear immediately; any partial slot is abandoned.

Optional Feature:
- Macro: SX_SLOT_ARB_STAT_EN.
- Defined: adds output stat_bytes [N_SRC*32-1:0] (per-source data bytes delivered, wrapping) and stat_pad [31:0] (total pad bytes).
  - Counters increment on the tx beat cycle and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package sx_pkg holds:
  - state enum constants (IDLE, ARB, READ, PAD, DRAIN), one-hot 5-bit;
  - PAD_BYTE default;
  - CH1/CH2 encodings.
- One sub-module, sx_rr_pick: combinational round-robin priority encoder taking (eligible, rr_ptr) and returning (hit, idx).

Test Plan:
- src0 cnt=5, others empty, slot ch2 len=8 -> tx_data2: 5 src0 bytes, then 3×0xAA; first valid 3 cycles after slot_req; tx_data1_valid_in stays 0.
- All 4 sources cnt≥20, four ch1 slots len=10 -> grant_id sequence 0,1,2,3; each slot 10 data bytes, no pad.
- All empty, slot ch1 len=4 -> 4×0xAA on ch1; rr_ptr unchanged; src_rd_en never asserted.
- slot_req during busy, and slot_len=0 in IDLE -> slot_ovr pulses once each; output stream of the active slot unchanged.
- src_en=4'b0100, src1/src2 non-empty -> src2 granted; assert rst mid-READ -> all outputs 0 the next cycle, next slot restarts from rr_ptr=0.
- SX_SLOT_ARB_STAT_EN defined, run the first scenario -> stat_bytes[src0]=5, stat_pad=3.
